// File: rtl/bram_arb_pkg.sv
// Shared defaults and types for the block-RAM port arbiter: default widths,
// requester-id width helper and the tagged read-response record.
package bram_arb_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_AW   = 11;
    localparam int DEF_DW   = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDW = id_w(DEF_NREQ);

    typedef struct packed {
        logic [DEF_IDW-1:0] id;
        logic [DEF_DW-1:0]  data;
    } rsp_t;

endpackage

// File: rtl/bram_arb_rsp_fifo.sv
// Small synchronous FIFO holding tagged read responses; show-ahead output
// with a live occupancy count that the arbiter uses for read credit.
module bram_arb_rsp_fifo
    import bram_arb_pkg::*;
#(
    parameter type T      = rsp_t,
    parameter int  DEPTH  = 4,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic          valid,
    output logic [CW-1:0] count
);

    T             mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign dout   = valid ? mem[rptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; dout is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= din;
    end

    // Read credit accounting upstream must keep the FIFO from overflowing.
    no_push_when_full_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && (count == CW'(DEPTH))));

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between NREQ requesters, with
// registered port drive and a credit-limited tagged response FIFO.
// Optional BRAM_ARB_PRIO_EN: requester 0 gets strict priority over the RR search.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int  NREQ      = DEF_NREQ,
    parameter int  AW        = DEF_AW,
    parameter int  DW        = DEF_DW,
    parameter int  RSP_DEPTH = 4,
    localparam int IDW       = id_w(NREQ)
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic               ram_en,
    output logic               ram_we,
    output logic               ram_ssr,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    input  logic [DW-1:0]      ram_dout,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW-1:0]      rsp_data,
    output logic [IDW-1:0]     rsp_id
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int SW = IDW + 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } rsp_entry_t;

    logic             active;
    logic [IDW-1:0]   ptr;
    logic             rd_ok;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gidx;
    logic             hs;
    logic             adv;
    logic [SW-1:0]    sum;
    logic [IDW-1:0]   idx;
    logic             rd_vld_p1;
    logic             rd_vld_p2;
    logic [IDW-1:0]   rd_id_p1;
    logic [IDW-1:0]   rd_id_p2;
    logic [CW-1:0]    fifo_cnt;
    rsp_entry_t       push_ent;
    rsp_entry_t       pop_ent;

    // A read may only issue if its response is guaranteed a FIFO slot.
    assign rd_ok = (int'(fifo_cnt) + int'(rd_vld_p1) + int'(rd_vld_p2)) < RSP_DEPTH;
    assign elig  = {NREQ{active}} & (req_we | {NREQ{rd_ok}});

    always_comb begin
        grant = '0;
        gidx  = '0;
        hs    = 1'b0;
        adv   = 1'b0;
        sum   = '0;
        idx   = '0;
`ifdef BRAM_ARB_PRIO_EN
        if (req_valid[0] && elig[0]) begin
            grant[0] = 1'b1;
            hs       = 1'b1;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            sum = SW'(ptr) + SW'(k);
            if (sum >= SW'(NREQ))
                sum = sum - SW'(NREQ);
            idx = sum[IDW-1:0];
            if (!hs && req_valid[idx] && elig[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                hs         = 1'b1;
                adv        = 1'b1;
            end
        end
    end

    assign req_ready = grant;

    // active keeps grants off while reset is asserted despite the combinational path.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
            ptr    <= '0;
        end else begin
            active <= 1'b1;
            if (adv)
                ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            rd_vld_p1 <= 1'b0;
            rd_id_p1  <= '0;
            rd_vld_p2 <= 1'b0;
            rd_id_p2  <= '0;
        end else begin
            // S1: RAM port drive
            ram_en <= hs;
            ram_we <= hs & req_we[gidx];
            if (hs) begin
                ram_addr <= req_addr[int'(gidx)*AW +: AW];
                ram_din  <= req_wdata[int'(gidx)*DW +: DW];
            end
            rd_vld_p1 <= hs & ~req_we[gidx];
            rd_id_p1  <= gidx;
            // S2: RAM data valid, tag travels alongside
            rd_vld_p2 <= rd_vld_p1;
            rd_id_p2  <= rd_id_p1;
        end
    end

    assign ram_ssr  = 1'b0;
    assign push_ent = {rd_id_p2, ram_dout};

    bram_arb_rsp_fifo #(
        .T     (rsp_entry_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (CLK),
        .reset_n (reset_n),
        .push    (rd_vld_p2),
        .din     (push_ent),
        .pop     (rsp_ready),
        .dout    (pop_ent),
        .valid   (rsp_valid),
        .count   (fifo_cnt)
    );

    assign rsp_data = pop_ent.data;
    assign rsp_id   = pop_ent.id;

endmodule
